// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the single-port frame RAM between the display read
// path (always wins) and the sequential loader stream (fills idle cycles).
// Tracks frame completeness for the HDMI timing controller and flags loader
// protocol errors (short/long frames).
module frame_mem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int IMG_PIXELS = 307200,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK_PX,
    input  logic              RST_n,
    // display read path
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic [DATA_W-1:0] DISP_DATA,
    output logic              DISP_VALID,
    // loader stream
    input  logic              WR_VALID,
    input  logic              WR_SOF,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_READY,
    // frame RAM
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    // status
    output logic              FRAME_READY,
    output logic              ERR
);

    typedef enum logic [1:0] {
        WAIT_SOF,
        LOAD,
        FULL
    } state_t;

    // Explicit compare against the last pixel so wr_addr wraps to 0 at the
    // frame size instead of at the natural 2^ADDR_W overflow.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              frame_ready_nxt, err_nxt;
    logic              xfer;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_tgt;

    // vld_pipe[0..RD_LATENCY-1] tracks reads in flight inside the RAM;
    // the extra top bit is the registered DISP_VALID.
    logic [RD_LATENCY:0] vld_pipe;

    // The loader is stalled in any cycle the display owns the RAM, and
    // during reset so nothing is accepted while the FSM is being cleared.
    assign WR_READY = RST_n && !DISP_REQ;
    assign xfer     = WR_VALID && WR_READY;

    // Next-state, write-address and status decode for each loader transfer.
    always_comb begin
        state_nxt       = state;
        wr_addr_nxt     = wr_addr;
        frame_ready_nxt = FRAME_READY;
        err_nxt         = ERR;
        wr_en           = 1'b0;
        // SOF always restarts at address 0, which also gives it precedence
        // over the last-pixel check below.
        wr_tgt          = WR_SOF ? '0 : wr_addr;
        if (xfer) begin
            case (state)
                WAIT_SOF: begin
                    // Pixels before the first SOF are silently dropped.
                    if (WR_SOF) begin
                        wr_en       = 1'b1;
                        wr_addr_nxt = ADDR_ONE;
                        state_nxt   = LOAD;
                    end
                end
                LOAD: begin
                    wr_en = 1'b1;
                    if (WR_SOF) begin
                        // New frame before the old one finished: short frame.
                        wr_addr_nxt = ADDR_ONE;
                        err_nxt     = 1'b1;
                    end else if (wr_addr == LAST_ADDR) begin
                        wr_addr_nxt     = '0;
                        frame_ready_nxt = 1'b1;
                        state_nxt       = FULL;
                    end else begin
                        wr_addr_nxt = wr_addr + ADDR_ONE;
                    end
                end
                FULL: begin
                    if (WR_SOF) begin
                        // Reload over the displayed frame; tearing is tolerated.
                        wr_en       = 1'b1;
                        wr_addr_nxt = ADDR_ONE;
                        state_nxt   = LOAD;
                    end else begin
                        // Extra pixel past the end of the frame: long frame.
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt   = WAIT_SOF;
                    wr_addr_nxt = '0;
                end
            endcase
        end
    end

    // RAM port mux: display reads take the port outright.
    always_comb begin
        MEM_ADDR  = DISP_REQ ? DISP_ADDR : wr_tgt;
        MEM_WE    = wr_en;
        MEM_WDATA = WR_DATA;
    end

    // FSM, write address and sticky status registers.
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            state       <= WAIT_SOF;
            wr_addr     <= '0;
            FRAME_READY <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_addr     <= wr_addr_nxt;
            FRAME_READY <= frame_ready_nxt;
            ERR         <= err_nxt;
        end
    end

    // Read-valid shift register matching the RAM latency, plus output stage.
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= DISP_REQ;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign DISP_VALID = vld_pipe[RD_LATENCY];

    // Capture returned pixel when the oldest in-flight read lands; hold otherwise.
    always_ff @(posedge CLK_PX or negedge RST_n) begin
        if (!RST_n) begin
            DISP_DATA <= '0;
        end else if (vld_pipe[RD_LATENCY-1]) begin
            DISP_DATA <= MEM_RDATA;
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a frame-position model and a RAM model.
module tb_frame_mem_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int NP = 16;
    localparam int RL = 1;

    logic          CLK_PX = 1'b0;
    logic          RST_n  = 1'b0;
    logic          DISP_REQ = 1'b0;
    logic [AW-1:0] DISP_ADDR = '0;
    logic [DW-1:0] DISP_DATA;
    logic          DISP_VALID;
    logic          WR_VALID = 1'b0;
    logic          WR_SOF = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          WR_READY;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          FRAME_READY;
    logic          ERR;

    frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IMG_PIXELS(NP), .RD_LATENCY(RL)) dut (
        .CLK_PX(CLK_PX), .RST_n(RST_n),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
        .WR_VALID(WR_VALID), .WR_SOF(WR_SOF), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .FRAME_READY(FRAME_READY), .ERR(ERR)
    );

    always #5 CLK_PX = ~CLK_PX;

    // Frame RAM with one cycle of read latency.
    logic [DW-1:0] ram [0:31];
    logic [DW-1:0] rdq = '0;
    always @(posedge CLK_PX) begin
        if (MEM_WE) ram[MEM_ADDR[4:0]] <= MEM_WDATA;
        rdq <= ram[MEM_ADDR[4:0]];
    end
    assign MEM_RDATA = rdq;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Model: position in the current frame, whether a frame has begun or
    // has been completed, and a copy of what the RAM should hold.
    bit            m_started, m_full, m_fr, m_err;
    int            m_pos;
    logic [DW-1:0] mm [0:NP-1];
    int            dq_due[$];
    logic [DW-1:0] dq_dat[$];
    logic [DW-1:0] m_last;
    int            cyc = 0;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        for (int i = 0; i < NP; i++) mm[i] = '0;
        m_last = '0;
    end

    always @(negedge CLK_PX) begin
        bit          xf, we, ev;
        logic [31:0] ea;
        if (!RST_n) begin
            m_started = 0; m_full = 0; m_fr = 0; m_err = 0; m_pos = 0;
            dq_due.delete(); dq_dat.delete(); m_last = '0;
        end
        ev = 0;
        if (dq_due.size() > 0 && dq_due[0] == cyc) begin
            ev = 1;
            m_last = dq_dat[0];
            void'(dq_due.pop_front());
            void'(dq_dat.pop_front());
        end
        chk("disp_valid", DISP_VALID, ev);
        chk("disp_data", DISP_DATA, m_last);
        chk("frame_ready", FRAME_READY, m_fr);
        chk("err", ERR, m_err);

        xf = RST_n && WR_VALID && !DISP_REQ;
        we = 0;
        ea = DISP_REQ ? 32'(DISP_ADDR) : 32'd0;
        if (xf) begin
            if (WR_SOF) begin
                we = 1; ea = 0;
                if (m_started && !m_full) m_err = 1;
                m_started = 1; m_full = 0;
                mm[0] = WR_DATA;
                m_pos = 1;
            end else if (m_started && !m_full) begin
                we = 1; ea = 32'(m_pos);
                mm[m_pos] = WR_DATA;
                if (m_pos == NP - 1) begin
                    m_full = 1; m_fr = 1; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end else if (m_full) begin
                m_err = 1;
            end
        end
        chk("wr_ready", WR_READY, RST_n && !DISP_REQ);
        chk("mem_we", MEM_WE, we);
        if (DISP_REQ || we) chk("mem_addr", MEM_ADDR, ea);
        if (we) chk("mem_wdata", MEM_WDATA, WR_DATA);
        if (RST_n && DISP_REQ) begin
            dq_due.push_back(cyc + 2);
            dq_dat.push_back(mm[DISP_ADDR[3:0]]);
        end
        cyc++;
    end

    bit alt = 1'b1;

    task automatic step();
        @(posedge CLK_PX);
        #1;
    endtask

    task automatic idle();
        WR_VALID = 0; WR_SOF = 0; DISP_REQ = 0;
    endtask

    task automatic rand_inputs();
        DISP_REQ  = 1'($urandom_range(0, 1));
        DISP_ADDR = AW'($urandom_range(0, 15));
        WR_VALID  = 1'($urandom_range(0, 1));
        WR_SOF    = 1'($urandom_range(0, 1));
        WR_DATA   = DW'($urandom);
    endtask

    // Offer one pixel and hold it until accepted; mode 1 interleaves display
    // requests to address 5 on alternate cycles.
    task automatic send_px(input logic [DW-1:0] d, input logic s, input int mode);
        bit acc = 0;
        WR_VALID = 1; WR_SOF = s; WR_DATA = d;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (mode == 1) begin
                DISP_REQ = alt; DISP_ADDR = AW'(5); alt = ~alt;
            end else begin
                DISP_REQ = 0;
            end
            acc = !DISP_REQ;
            step();
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int mode);
        for (int i = 0; i < NP; i++) send_px(base + DW'(i), i == 0, mode);
    endtask

    task automatic do_reset(input int n);
        RST_n = 0;
        repeat (n) begin rand_inputs(); step(); end
        idle();
        RST_n = 1;
        step();
    endtask

    initial begin
        bit pend;
        // reset with toggling inputs
        RST_n = 0;
        repeat (6) begin
            rand_inputs();
            #1;
            chk("rst_wr_ready", WR_READY, 0);
            chk("rst_mem_we", MEM_WE, 0);
            chk("rst_fr", FRAME_READY, 0);
            chk("rst_err", ERR, 0);
            chk("rst_dvalid", DISP_VALID, 0);
            chk("rst_ddata", DISP_DATA, 0);
            step();
        end
        idle();
        RST_n = 1;
        step();

        // basic load
        for (int i = 0; i < NP; i++) begin
            send_px(8'h10 + DW'(i), i == 0, 0);
            if (i == NP - 2) chk("fr_early", FRAME_READY, 0);
            if (i == NP - 1) chk("fr_rise", FRAME_READY, 1);
        end
        idle(); step();
        for (int i = 0; i < NP; i++) chk("basic_ram", ram[i], 8'h10 + DW'(i));
        chk("basic_err", ERR, 0);

        // contention (reload over a full frame)
        send_frame(8'h20, 1);
        idle(); repeat (3) step();
        for (int i = 0; i < NP; i++) chk("cont_ram", ram[i], 8'h20 + DW'(i));
        chk("cont_err", ERR, 0);
        chk("cont_fr", FRAME_READY, 1);

        // pre-SOF pixels are dropped
        do_reset(2);
        for (int i = 0; i < 3; i++) send_px(8'hA0 + DW'(i), 0, 0);
        idle(); step();
        chk("presof_ram0", ram[0], 8'h20);
        chk("presof_fr", FRAME_READY, 0);
        send_frame(8'h30, 0);
        idle(); step();
        chk("presof_ram0b", ram[0], 8'h30);
        chk("presof_ram15", ram[15], 8'h3F);
        chk("presof_err", ERR, 0);

        // short frame
        do_reset(2);
        for (int i = 0; i < 5; i++) send_px(8'h40 + DW'(i), i == 0, 0);
        chk("short_err0", ERR, 0);
        send_px(8'h55, 1, 0);
        idle(); step();
        chk("short_ram0", ram[0], 8'h55);
        chk("short_err1", ERR, 1);

        // long frame
        do_reset(2);
        send_frame(8'h60, 0);
        chk("long_err0", ERR, 0);
        send_px(8'h77, 0, 0);
        idle(); step();
        chk("long_err1", ERR, 1);
        chk("long_fr", FRAME_READY, 1);
        chk("long_ram0", ram[0], 8'h60);

        // reset in the middle of a reload
        for (int i = 0; i < 8; i++) send_px(8'h80 + DW'(i), i == 0, 0);
        idle();
        RST_n = 0; step();
        chk("midrst_fr", FRAME_READY, 0);
        chk("midrst_err", ERR, 0);
        RST_n = 1; step();
        send_px(8'h99, 0, 0);
        idle(); step();
        chk("midrst_drop8", ram[8], 8'h68);
        chk("midrst_ram0", ram[0], 8'h80);
        send_frame(8'h90, 0);
        chk("midrst_fr1", FRAME_READY, 1);
        idle(); step();
        chk("midrst_ram15", ram[15], 8'h9F);

        // randomized traffic, loader holds its offer until accepted
        pend = 0;
        repeat (3000) begin
            RST_n = ($urandom_range(0, 399) != 0);
            if (!pend) begin
                WR_VALID = ($urandom_range(0, 3) != 0);
                WR_SOF   = ($urandom_range(0, 17) == 0);
                WR_DATA  = DW'($urandom);
            end
            DISP_REQ  = ($urandom_range(0, 2) == 0);
            DISP_ADDR = AW'($urandom_range(0, 15));
            pend = WR_VALID && !(RST_n && !DISP_REQ);
            step();
        end
        idle();
        RST_n = 1;
        repeat (4) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
